// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Latency: lookup is combinational (zero cycles); updates take effect from the cycle after the update edge.
// Backpressure: none; one lookup and at most one update are accepted every cycle.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        predicted_taken,
  output logic [31:0] predicted_pc,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken
);

  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Per-entry state
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  // Address split; the low two PC bits never participate
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             fetch_hit;
  logic             upd_hit;
  logic             unused_low_bits;

  assign fetch_idx       = fetch_pc[IDX_W+1:2];
  assign fetch_tag       = fetch_pc[31:IDX_W+2];
  assign upd_idx         = update_pc[IDX_W+1:2];
  assign upd_tag         = update_pc[31:IDX_W+2];
  assign unused_low_bits = ^{fetch_pc[1:0], update_pc[1:0]};

  // Lookup reads only the registered state, so a same-cycle update is never bypassed
  always_comb begin
    fetch_hit       = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    predicted_taken = fetch_hit && ctr_q[fetch_idx][1];
    predicted_pc    = predicted_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;
  end

  // Update-side hit detection against the entry the resolving branch maps to
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  end

  // Train on resolved branches: counter steps on hits, taken misses allocate at weak-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (update_en) begin
      if (upd_hit) begin
        if (update_taken) begin
          target_q[upd_idx] <= update_target;
          if (ctr_q[upd_idx] != CTR_ST) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
          end
        end else if (ctr_q[upd_idx] != CTR_SNT) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (update_taken) begin
        // A taken miss evicts whatever alias currently holds the slot
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= update_target;
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter: ENTRIES, 16, number of direct-mapped entries (power of two).
REQ-002 SHALL have parameter: IDX_W, 4, index width, log2(ENTRIES); tag width is TAG_W = 30 - IDX_W.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: fetch_pc  input  32  PC being fetched this cycle.
REQ-006 SHALL have port: predicted_taken  output  1  prediction for fetch_pc; feeds the execute-stage predictedTaken pipeline bit.
REQ-007 SHALL have port: predicted_pc  output  32  next fetch PC chosen by the predictor.
REQ-008 SHALL have port: update_en  input  1  execute stage resolves a branch or jump (update_btb).
REQ-009 SHALL have port: update_pc  input  32  PC of the resolving instruction.
REQ-010 SHALL have port: update_target  input  32  resolved target (jump_addr).
REQ-011 SHALL have port: update_taken  input  1  resolved direction (1 for all JAL/JALR).

Function
REQ-012 SHALL hold per entry: valid (1), tag (TAG_W), target (32), 2-bit saturating counter ctr.
REQ-013 SHALL index with pc[IDX_W+1:2] and tag with pc[31:IDX_W+2]; pc[1:0] ignored.
REQ-014 SHALL compute lookup combinationally, zero latency: hit = valid[idx] AND tag[idx] == fetch_pc tag.
REQ-015 SHALL drive predicted_taken = hit AND ctr[idx][1].
REQ-016 SHALL drive predicted_pc = target[idx] when predicted_taken, else fetch_pc + 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
REQ-017 SHALL encode ctr states as: 00 strong-not-taken (SNT), 01 weak-not-taken (WNT), 10 weak-taken (WT), 11 strong-taken (ST).
REQ-018 SHALL, on a rising edge with update_en=1 and an update hit (valid, tag match at update index), increment ctr if update_taken, else decrement ctr.
REQ-019 SHALL saturate ctr: ST stays ST on taken; SNT stays SNT on not-taken.
REQ-020 SHALL, on an update hit with update_taken=1, overwrite target with update_target; on not-taken, leave target unchanged.
REQ-021 SHALL, on update miss with update_taken=1, allocate: valid=1, tag=update tag, target=update_target, ctr=WT (10), replacing any prior occupant.
REQ-022 SHALL, on update miss with update_taken=0, leave the entry unchanged (no allocation).
REQ-023 SHALL leave state unchanged when update_en=0.
REQ-024 SHALL, when lookup and update address the same entry in one cycle, return pre-update contents; the new contents are visible from the next cycle (no bypass).
REQ-025 SHALL update at most one entry per cycle; other entries hold.

Reset
REQ-026 SHALL, on rst_n=0 asynchronously, clear every valid bit, set every ctr to WNT (01), and clear every tag and target to 0.
REQ-027 SHALL, during and immediately after reset, output predicted_taken=0 and predicted_pc=fetch_pc+4.
REQ-028 SHALL, on reset asserted mid-update edge, discard the update; reset dominates.

Verification
REQ-029 SHALL cover: after reset, fetch_pc=0x00000100 -> predicted_taken=0, predicted_pc=0x00000104.
REQ-030 SHALL cover: update_en=1, update_pc=0x00000100, update_taken=1, update_target=0x00000200; next cycle fetch_pc=0x00000100 -> predicted_taken=1, predicted_pc=0x00000200.
REQ-031 SHALL cover: from WT, two not-taken updates at 0x00000100 -> ctr WT->WNT->SNT, predicted_pc=0x00000104; a third not-taken keeps SNT; then two taken updates -> WT, predicted_taken=1.
REQ-032 SHALL cover aliasing: entry 0x00000100 allocated, then a taken update at 0x00000140 (same index, different tag) with target 0x00000300 -> 0x00000100 misses (predicted_pc=0x00000104) and 0x00000140 predicts 0x00000300.
REQ-033 SHALL cover same-cycle conflict: lookup and allocating update both at 0x00000180 -> that cycle predicted_taken=0; the next cycle predicted_taken=1.
REQ-034 SHALL cover async reset: rst_n pulsed low between edges with entries valid -> outputs revert to not-taken at once; a lookup of 0xFFFFFFFC yields predicted_pc=0x00000000.
